// File: rtl/alu_b_operand_stage_pkg.sv
// rtl/alu_b_operand_stage_pkg.sv - shared types and constants for the ALU B operand stage
package alu_b_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int REG_ADDR_W   = 5;

  typedef enum logic {
    SRC_RS2 = 1'b0,
    SRC_IMM = 1'b1
  } alu_b_src_e;

endpackage

// File: rtl/alu_b_operand_stage_if.sv
// rtl/alu_b_operand_stage_if.sv - request, forwarding and operand signals of the B operand stage
interface alu_b_operand_stage_if
  import alu_b_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int NUM_FWD = 2
);

  logic                          in_valid;
  logic                          in_ready;
  logic                          alu_b_src;
  logic [REG_ADDR_W-1:0]         rs2_addr;
  logic [XLEN-1:0]               rs2_data;
  logic [XLEN-1:0]               imm_data;
  logic [NUM_FWD-1:0]            fwd_valid;
  logic [NUM_FWD-1:0]            fwd_busy;
  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0]       fwd_data;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [XLEN-1:0]               out_operand;
  logic                          out_fwd_hit;
  logic [15:0]                   stall_count;

  modport master (
    output in_valid, alu_b_src, rs2_addr, rs2_data, imm_data,
           fwd_valid, fwd_busy, fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_operand, out_fwd_hit, stall_count
  );

  modport slave (
    input  in_valid, alu_b_src, rs2_addr, rs2_data, imm_data,
           fwd_valid, fwd_busy, fwd_rd, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_operand, out_fwd_hit, stall_count
  );

endinterface

// File: rtl/alu_b_operand_stage_fwd_match.sv
// rtl/alu_b_operand_stage_fwd_match.sv - priority match of rs2 against forwarding destinations
module fwd_match
  import alu_b_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int IDX_W   = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1
) (
  input  logic [REG_ADDR_W-1:0]         i_rs2_addr,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_rd,
  output logic                          o_hit,
  output logic [NUM_FWD-1:0]            o_sel,
  output logic [IDX_W-1:0]              o_idx
);

  // Walk from the oldest source down so the youngest (lowest index) match wins.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    o_idx = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_valid[i] && (i_fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == i_rs2_addr)) begin
        o_hit    = 1'b1;
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_b_operand_stage.sv
// rtl/alu_b_operand_stage.sv - selects, forwards and registers the ALU B operand with hazard stall
module alu_b_operand_stage
  import alu_b_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int NUM_FWD = 2
) (
  input logic                  clk,
  input logic                  rst,
  alu_b_operand_stage_if.slave bus
);

  localparam int IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

  logic               w_match_hit;
  logic [NUM_FWD-1:0] w_match_sel;
  logic [IDX_W-1:0]   w_match_idx;
  alu_b_src_e         w_src;
  logic               w_use_rs2;
  logic               w_fwd_hit;
  logic               w_hazard;
  logic [XLEN-1:0]    w_fwd_value;
  logic [XLEN-1:0]    w_operand;
  logic               w_in_ready;
  logic               w_xfer;

  logic               r_out_valid;
  logic [XLEN-1:0]    r_out_operand;
  logic               r_out_fwd_hit;
  logic [15:0]        r_stall_count;

  fwd_match #(
    .NUM_FWD (NUM_FWD),
    .IDX_W   (IDX_W)
  ) u_fwd_match (
    .i_rs2_addr  (bus.rs2_addr),
    .i_fwd_valid (bus.fwd_valid),
    .i_fwd_rd    (bus.fwd_rd),
    .o_hit       (w_match_hit),
    .o_sel       (w_match_sel),
    .o_idx       (w_match_idx)
  );

  assign w_src       = alu_b_src_e'(bus.alu_b_src);
  assign w_use_rs2   = (w_src == SRC_RS2) && (bus.rs2_addr != '0);
  assign w_fwd_hit   = w_use_rs2 && w_match_hit;
  // Only the winning source's busy bit matters; older busy entries are masked.
  assign w_hazard    = w_fwd_hit && |(w_match_sel & bus.fwd_busy);
  assign w_fwd_value = bus.fwd_data[w_match_idx*XLEN +: XLEN];

  always_comb begin
    w_operand = bus.rs2_data;
    if (w_src == SRC_IMM) begin
      w_operand = bus.imm_data;
    end else if (bus.rs2_addr == '0) begin
      w_operand = '0;
    end else if (w_match_hit) begin
      w_operand = w_fwd_value;
    end
  end

  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_xfer     = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_operand <= '0;
      r_out_fwd_hit <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_xfer) begin
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_xfer) begin
        r_out_operand <= w_operand;
        r_out_fwd_hit <= w_fwd_hit;
      end

      if (bus.in_valid && w_hazard && !bus.flush && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_operand = r_out_operand;
  assign bus.out_fwd_hit = r_out_fwd_hit;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// tb/tb_alu_b_operand_stage.sv - directed self-checking bench for alu_b_operand_stage
module tb_alu_b_operand_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_b_operand_stage_if #(.XLEN(32), .NUM_FWD(2)) bus ();

  alu_b_operand_stage #(.XLEN(32), .NUM_FWD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_b_src = 1'b0;
    bus.rs2_addr  = 5'd0;
    bus.rs2_data  = '0;
    bus.imm_data  = '0;
    bus.fwd_valid = '0;
    bus.fwd_busy  = '0;
    bus.fwd_rd    = '0;
    bus.fwd_data  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_operand", bus.out_operand, 32'd0);
    check("rst_hit", 32'(bus.out_fwd_hit), 32'd0);
    check("rst_stall", 32'(bus.stall_count), 32'd0);
    rst = 1'b0;
    step();

    // immediate select
    bus.in_valid  = 1'b1;
    bus.alu_b_src = 1'b1;
    bus.imm_data  = 32'h0000_0010;
    bus.rs2_data  = 32'h5;
    bus.rs2_addr  = 5'd3;
    #1;
    check("imm_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("imm_valid", 32'(bus.out_valid), 32'd1);
    check("imm_operand", bus.out_operand, 32'h10);
    check("imm_hit", 32'(bus.out_fwd_hit), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // both sources match: youngest wins
    bus.in_valid  = 1'b1;
    bus.alu_b_src = 1'b0;
    bus.rs2_addr  = 5'd3;
    bus.fwd_valid = 2'b11;
    bus.fwd_rd    = {5'd3, 5'd3};
    bus.fwd_data  = {32'h0000_BBBB, 32'h0000_AAAA};
    step();
    check("fwd0_operand", bus.out_operand, 32'hAAAA);
    check("fwd0_hit", 32'(bus.out_fwd_hit), 32'd1);

    bus.fwd_valid = 2'b10;
    step();
    check("fwd1_valid", 32'(bus.out_valid), 32'd1);
    check("fwd1_operand", bus.out_operand, 32'hBBBB);
    check("fwd1_hit", 32'(bus.out_fwd_hit), 32'd1);

    bus.fwd_rd   = {5'd7, 5'd7};
    bus.rs2_data = 32'h0000_CAFE;
    step();
    check("rf_operand", bus.out_operand, 32'hCAFE);
    check("rf_hit", 32'(bus.out_fwd_hit), 32'd0);

    // x0 never forwards
    bus.rs2_addr  = 5'd0;
    bus.fwd_valid = 2'b01;
    bus.fwd_rd    = {5'd7, 5'd0};
    bus.fwd_data  = {32'h0, 32'h0000_1234};
    step();
    check("x0_operand", bus.out_operand, 32'h0);
    check("x0_hit", 32'(bus.out_fwd_hit), 32'd0);

    // load-use hazard for three cycles
    bus.rs2_addr  = 5'd5;
    bus.fwd_rd    = {5'd7, 5'd5};
    bus.fwd_data  = {32'h0, 32'h0000_0055};
    bus.fwd_busy  = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hz_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    check("hz_stall", 32'(bus.stall_count), 32'd3);
    check("hz_idle", 32'(bus.out_valid), 32'd0);
    bus.fwd_busy = 2'b00;
    #1;
    check("hz_release", 32'(bus.in_ready), 32'd1);
    step();
    check("hz_operand", bus.out_operand, 32'h55);
    check("hz_hit", 32'(bus.out_fwd_hit), 32'd1);
    check("hz_stall_hold", 32'(bus.stall_count), 32'd3);

    // busy older source is masked by a ready younger match
    bus.fwd_valid = 2'b11;
    bus.fwd_rd    = {5'd5, 5'd5};
    bus.fwd_data  = {32'h0000_0066, 32'h0000_0056};
    bus.fwd_busy  = 2'b10;
    #1;
    check("mask_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("mask_operand", bus.out_operand, 32'h56);
    bus.fwd_busy = 2'b01;
    #1;
    check("mask_busy_ready", 32'(bus.in_ready), 32'd0);

    // backpressure hold, then flush wins over transfer
    bus.fwd_busy  = 2'b00;
    bus.alu_b_src = 1'b1;
    bus.imm_data  = 32'h77;
    step();
    check("bp_load", bus.out_operand, 32'h77);
    bus.out_ready = 1'b0;
    bus.imm_data  = 32'h99;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_operand", bus.out_operand, 32'h77);
    end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("fl_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("fl_valid", 32'(bus.out_valid), 32'd0);
    check("fl_operand", bus.out_operand, 32'h77);
    check("fl_stall", 32'(bus.stall_count), 32'd3);

    // asynchronous reset between edges
    bus.in_valid = 1'b1;
    bus.imm_data = 32'h1234;
    step();
    bus.in_valid = 1'b0;
    check("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_operand", bus.out_operand, 32'd0);
    check("ar_stall", 32'(bus.stall_count), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.imm_data = 32'h42;
    step();
    check("ar_first_valid", 32'(bus.out_valid), 32'd1);
    check("ar_first_operand", bus.out_operand, 32'h42);

    // flush suppresses stall counting, then saturation
    bus.out_ready = 1'b1;
    bus.alu_b_src = 1'b0;
    bus.rs2_addr  = 5'd5;
    bus.fwd_valid = 2'b01;
    bus.fwd_rd    = {5'd0, 5'd5};
    bus.fwd_busy  = 2'b01;
    bus.flush     = 1'b1;
    step();
    step();
    check("fl_nostall", 32'(bus.stall_count), 32'd0);
    bus.flush = 1'b0;
    repeat (65540) step();
    check("sat_stall", 32'(bus.stall_count), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
